// File: rtl/sram_arbiter_if.sv
// -----------------------------------------------------------------------------
// sram_arbiter_if
//   Bundles the requester-side command/response signals and the SRAM-side
//   command/read-data signals of the SRAM arbiter.
//
//   Requester side (packed, requester i at slice i):
//     req_valid[NUM_REQ]            command valid
//     req_ready[NUM_REQ]            command accepted (one-hot or zero)
//     req_we[NUM_REQ]               1 = write, 0 = read
//     req_addr[NUM_REQ*ADDR_WIDTH]  command address
//     req_wdata[NUM_REQ*DATA_WIDTH] write data
//     rsp_valid[NUM_REQ]            read data valid for requester i (pulse)
//     rsp_data[DATA_WIDTH]          shared read data
//   SRAM side:
//     sram_cs, sram_we, sram_addr, sram_din   registered SRAM command
//     sram_dout                               SRAM read data (1-cycle latency)
//
//   Modports: slave = arbiter view, master = requesters + SRAM view.
// -----------------------------------------------------------------------------
interface sram_arbiter_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int NUM_REQ    = 2
);

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ-1:0]            req_we;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;
  logic [NUM_REQ-1:0]            rsp_valid;
  logic [DATA_WIDTH-1:0]         rsp_data;

  logic                          sram_cs;
  logic                          sram_we;
  logic [ADDR_WIDTH-1:0]         sram_addr;
  logic [DATA_WIDTH-1:0]         sram_din;
  logic [DATA_WIDTH-1:0]         sram_dout;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, sram_dout,
    output req_ready, rsp_valid, rsp_data,
    output sram_cs, sram_we, sram_addr, sram_din
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata, sram_dout,
    input  req_ready, rsp_valid, rsp_data,
    input  sram_cs, sram_we, sram_addr, sram_din
  );

endinterface : sram_arbiter_if

// File: rtl/sram_arbiter.sv
// -----------------------------------------------------------------------------
// sram_arbiter
//   Round-robin arbiter giving NUM_REQ requesters shared access to a single
//   synchronous SRAM. One command is accepted per cycle; the command is
//   registered onto the SRAM pins the following cycle, and read data is
//   returned to the owning requester two cycles after acceptance.
//
//   Ports:
//     clk  - single clock, rising edge
//     rst  - asynchronous, active-high reset
//     bus  - sram_arbiter_if.slave: requester command/response bundle and
//            SRAM command/read-data bundle
//
//   Pipeline for a read accepted at edge E:
//     E   : command -> sram_* registers, read tag -> stage 1
//     E+1 : SRAM samples the command, read tag -> stage 2
//     E+2 : sram_dout -> rsp_data, rsp_valid[owner] pulses
// -----------------------------------------------------------------------------
module sram_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int NUM_REQ    = 2
) (
  input  logic          clk,
  input  logic          rst,
  sram_arbiter_if.slave bus
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  // Round-robin pointer: requester with highest priority this cycle.
  logic [PTR_W-1:0]      ptr_q, ptr_d;

  // Arbitration result.
  logic                  grant_vld;
  logic [PTR_W-1:0]      grant_idx;

  // SRAM command stage.
  logic                  cs_q, cs_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] din_q, din_d;

  // Read tracking: valid bit and owner, two stages alongside the SRAM access.
  logic                  rd_vld1_q, rd_vld1_d;
  logic [PTR_W-1:0]      rd_own1_q, rd_own1_d;
  logic                  rd_vld2_q;
  logic [PTR_W-1:0]      rd_own2_q;

  // Response stage.
  logic [NUM_REQ-1:0]    rsp_valid_q;
  logic [DATA_WIDTH-1:0] rsp_data_q;

  // ---------------------------------------------------------------------------
  // Arbitration: scan from the pointer, first asserted req_valid wins.
  // ---------------------------------------------------------------------------
  always_comb begin : arbitrate
    int idx;
    // NOTE: every combinationally assigned signal gets a default before any
    // conditional assignment, otherwise synthesis infers a latch.
    grant_vld = 1'b0;
    grant_idx = '0;
    idx       = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!grant_vld && bus.req_valid[idx]) begin
        grant_vld = 1'b1;
        grant_idx = PTR_W'(idx);
      end
    end
    // Ready must read zero while reset is held, even with requests pending.
    if (rst) grant_vld = 1'b0;
  end

  assign bus.req_ready = grant_vld ? (NUM_REQ'(1) << grant_idx) : '0;

  // ---------------------------------------------------------------------------
  // Next-state: capture the accepted command and advance the pointer.
  // ---------------------------------------------------------------------------
  always_comb begin : next_state
    ptr_d     = ptr_q;
    cs_d      = grant_vld;
    we_d      = 1'b0;
    addr_d    = addr_q;
    din_d     = din_q;
    rd_vld1_d = 1'b0;
    rd_own1_d = rd_own1_q;
    if (grant_vld) begin
      we_d      = bus.req_we[grant_idx];
      addr_d    = bus.req_addr[int'(grant_idx)*ADDR_WIDTH +: ADDR_WIDTH];
      din_d     = bus.req_wdata[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
      rd_vld1_d = ~bus.req_we[grant_idx];
      rd_own1_d = grant_idx;
      ptr_d     = (int'(grant_idx) == NUM_REQ - 1) ? '0
                                                   : PTR_W'(int'(grant_idx) + 1);
    end
  end

  // ---------------------------------------------------------------------------
  // State registers.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q       <= '0;
      cs_q        <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      din_q       <= '0;
      rd_vld1_q   <= 1'b0;
      rd_own1_q   <= '0;
      rd_vld2_q   <= 1'b0;
      rd_own2_q   <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      ptr_q       <= ptr_d;
      cs_q        <= cs_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      din_q       <= din_d;
      rd_vld1_q   <= rd_vld1_d;
      rd_own1_q   <= rd_own1_d;
      rd_vld2_q   <= rd_vld1_q;
      rd_own2_q   <= rd_own1_q;
      rsp_valid_q <= rd_vld2_q ? (NUM_REQ'(1) << rd_own2_q) : '0;
      // sram_dout is valid in the cycle after the SRAM sampled the read.
      if (rd_vld2_q) rsp_data_q <= bus.sram_dout;
    end
  end

  assign bus.sram_cs   = cs_q;
  assign bus.sram_we   = we_q;
  assign bus.sram_addr = addr_q;
  assign bus.sram_din  = din_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;

endmodule : sram_arbiter

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 8, SRAM word width.
REQ-002 Parameter ADDR_WIDTH, default 4, SRAM address width (2**ADDR_WIDTH words).
REQ-003 Parameter NUM_REQ, default 2, number of requesters (2..4).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 req_valid  input  NUM_REQ  per-requester command valid.
REQ-007 req_ready  output  NUM_REQ  per-requester command accepted (one-hot or zero).
REQ-008 req_we  input  NUM_REQ  per-requester 1=write, 0=read.
REQ-009 req_addr  input  NUM_REQ*ADDR_WIDTH  packed addresses; requester i at slice i.
REQ-010 req_wdata  input  NUM_REQ*DATA_WIDTH  packed write data; requester i at slice i.
REQ-011 rsp_valid  output  NUM_REQ  read-data valid for requester i, one-cycle pulse.
REQ-012 rsp_data  output  DATA_WIDTH  read data, shared; meaningful only while some rsp_valid bit is high.
REQ-013 sram_cs  output  1  SRAM chip select.
REQ-014 sram_we  output  1  SRAM write enable.
REQ-015 sram_addr  output  ADDR_WIDTH  SRAM address.
REQ-016 sram_din  output  DATA_WIDTH  SRAM write data.
REQ-017 sram_dout  input  DATA_WIDTH  SRAM read data, valid the cycle after a read is sampled.

Function
REQ-018 Arbitration: round-robin, combinational; req_ready[i]=1 only for the single winner among asserted req_valid bits; zero when no req_valid.
REQ-019 Priority pointer: after a grant to i, highest priority moves to (i+1) mod NUM_REQ; no grant -> pointer unchanged.
REQ-020 Acceptance: command i accepted at edge E when req_valid[i] & req_ready[i]; one accept per cycle max.
REQ-021 Command stage: sram_cs/we/addr/din registered; in cycle after E they carry the accepted command; sram_cs=0, sram_we=0 when nothing accepted.
REQ-022 Read tracking: per accepted read, owner index and valid bit pipelined two stages alongside the SRAM access.
REQ-023 Read latency: rsp_valid[owner]=1 with rsp_data=registered sram_dout exactly 2 cycles after acceptance edge E (visible after edge E+2).
REQ-024 Writes produce no rsp_valid; write-then-read same address on consecutive accepts returns the new data.
REQ-025 Throughput: one command per cycle sustained; back-to-back reads from different requesters return in acceptance order, each to its owner.
REQ-026 Single active requester is granted every cycle regardless of pointer.
REQ-027 Requester holding req_valid without ready keeps its command stable; arbiter makes no assumption otherwise.
REQ-028 At most one rsp_valid bit high per cycle.
REQ-029 Address and data widths passed unmodified; no wrap or arithmetic on addresses.

Reset
REQ-030 rst high: req_ready=0, rsp_valid=0, rsp_data=0, sram_cs=0, sram_we=0, sram_addr=0, sram_din=0, pointer=0 (requester 0 highest priority), pipeline valid bits cleared.
REQ-031 Reset mid-operation: in-flight reads discarded; no rsp_valid after rst deasserts until new reads accepted.
REQ-032 First arbitration occurs on first rising edge with rst low.

Verification
REQ-033 Reset, then requester 0 writes 0xA5 to addr 3, then reads addr 3 -> sram_cs/we=1/addr=3/din=0xA5 one cycle after write accept; rsp_valid[0]=1, rsp_data=0xA5 two cycles after read accept.
REQ-034 Both requesters hold valid reads (addr 1, addr 2) for 4 cycles -> grants alternate 0,1,0,1; rsp_valid alternates with matching data, 2-cycle latency each.
REQ-035 Only requester 1 valid for 3 cycles -> req_ready[1]=1 every cycle, three rsp_valid[1] pulses.
REQ-036 Write all 16 addresses via requester 1 with data = addr^0x5A, read back via requester 0 -> every rsp_data matches, no rsp_valid[1] observed.
REQ-037 Accept read, assert rst in following cycle for 2 cycles -> no rsp_valid ever, all outputs 0 during reset, pointer back to 0.
REQ-038 No req_valid for 5 cycles -> sram_cs=0, req_ready=0, rsp_valid=0 throughout.
